// File: rtl/regbank_pkg.sv
// regbank_pkg: shared sizes, register indices and reset constants for the 16x32 register bank
package regbank_pkg;
    localparam int DATA_W     = 32;
    localparam int NREGS      = 16;
    localparam int REG_ADDR_W = 4;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 4'd0;
    localparam logic [REG_ADDR_W-1:0] SP_IDX   = 4'd13;
    localparam logic [DATA_W-1:0]     SP_RESET = 32'h1001_03FC;
endpackage

// File: rtl/seletor_leitura_16x32.sv
// seletor_leitura_16x32: 16:1 32-bit read select; address 0 is forced to zero
//   i_words  all NREGS stored words
//   i_sel    4-bit read address
//   o_data   selected word (0 when i_sel is the zero register)
module seletor_leitura_16x32
    import regbank_pkg::*;
(
    input  logic [NREGS-1:0][DATA_W-1:0] i_words,
    input  logic [REG_ADDR_W-1:0]        i_sel,
    output logic [DATA_W-1:0]            o_data
);
    always_comb o_data = (i_sel == ZERO_REG) ? '0 : i_words[i_sel];
endmodule

// File: rtl/banco_registradores_16x32.sv
// banco_registradores_16x32: 16x32 register bank, one sync write port, three combinational read ports
//   iCLK/iRST                      clock, synchronous active-high reset
//   iRegWrite/iWriteReg/iWriteData write port
//   iReadReg1/2 -> oReadData1/2    operand read ports A and B
//   iDispReg -> oDispData          board display read port
//   oWriteCount                    committed-write counter (debug)
// Optional macro REGBANK_BYPASS_EN: write-through forwarding on ports A and B only.
module banco_registradores_16x32
    import regbank_pkg::*;
(
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iRegWrite,
    input  logic [REG_ADDR_W-1:0] iWriteReg,
    input  logic [DATA_W-1:0]     iWriteData,
    input  logic [REG_ADDR_W-1:0] iReadReg1,
    input  logic [REG_ADDR_W-1:0] iReadReg2,
    input  logic [REG_ADDR_W-1:0] iDispReg,
    output logic [DATA_W-1:0]     oReadData1,
    output logic [DATA_W-1:0]     oReadData2,
    output logic [DATA_W-1:0]     oDispData,
    output logic [15:0]           oWriteCount
);
    logic [NREGS-1:0][DATA_W-1:0] r_regs;
    logic [15:0]                  r_write_count;
    logic                         w_wr_en;
    logic [DATA_W-1:0]            w_rd1;
    logic [DATA_W-1:0]            w_rd2;

    // Writes to the zero register neither commit nor count.
    assign w_wr_en = iRegWrite && !iRST && (iWriteReg != ZERO_REG);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_regs         <= '0;
            r_regs[SP_IDX] <= SP_RESET;
            r_write_count  <= '0;
        end else if (w_wr_en) begin
            r_regs[iWriteReg] <= iWriteData;
            r_write_count     <= r_write_count + 16'd1;
        end
    end

    seletor_leitura_16x32 u_sel_a (.i_words(r_regs), .i_sel(iReadReg1), .o_data(w_rd1));
    seletor_leitura_16x32 u_sel_b (.i_words(r_regs), .i_sel(iReadReg2), .o_data(w_rd2));
    seletor_leitura_16x32 u_sel_d (.i_words(r_regs), .i_sel(iDispReg),  .o_data(oDispData));

`ifdef REGBANK_BYPASS_EN
    assign oReadData1 = (w_wr_en && iReadReg1 == iWriteReg) ? iWriteData : w_rd1;
    assign oReadData2 = (w_wr_en && iReadReg2 == iWriteReg) ? iWriteData : w_rd2;
`else
    assign oReadData1 = w_rd1;
    assign oReadData2 = w_rd2;
`endif

    assign oWriteCount = r_write_count;
endmodule

// File: tb/tb_banco_registradores_16x32.sv
// tb_banco_registradores_16x32: directed self-checking bench for the 16x32 register bank
module tb_banco_registradores_16x32;
    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iRegWrite;
    logic [3:0]  iWriteReg;
    logic [31:0] iWriteData;
    logic [3:0]  iReadReg1;
    logic [3:0]  iReadReg2;
    logic [3:0]  iDispReg;
    logic [31:0] oReadData1;
    logic [31:0] oReadData2;
    logic [31:0] oDispData;
    logic [15:0] oWriteCount;
    int          n_tests = 0;
    int          n_fail  = 0;

    banco_registradores_16x32 dut (
        .iCLK(iCLK), .iRST(iRST), .iRegWrite(iRegWrite), .iWriteReg(iWriteReg),
        .iWriteData(iWriteData), .iReadReg1(iReadReg1), .iReadReg2(iReadReg2),
        .iDispReg(iDispReg), .oReadData1(oReadData1), .oReadData2(oReadData2),
        .oDispData(oDispData), .oWriteCount(oWriteCount)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic read_all(input logic [3:0] a);
        iReadReg1 = a;
        iReadReg2 = a;
        iDispReg  = a;
        #1;
    endtask

    initial begin
        iRST = 1'b1; iRegWrite = 1'b0; iWriteReg = '0; iWriteData = '0;
        iReadReg1 = '0; iReadReg2 = '0; iDispReg = '0;
        tick();
        iRST = 1'b0;
        for (int a = 0; a < 16; a++) begin
            read_all(4'(a));
            check($sformatf("rst_a_r%0d", a), oReadData1, a == 13 ? 32'h1001_03FC : 32'h0);
            check($sformatf("rst_b_r%0d", a), oReadData2, a == 13 ? 32'h1001_03FC : 32'h0);
            check($sformatf("rst_d_r%0d", a), oDispData,  a == 13 ? 32'h1001_03FC : 32'h0);
        end
        check("rst_count", {16'h0, oWriteCount}, 32'h0);

        iRegWrite = 1'b1; iWriteReg = 4'd5; iWriteData = 32'hDEADBEEF;
        tick();
        iRegWrite = 1'b0;
        read_all(4'd5);
        check("wr5_a", oReadData1, 32'hDEADBEEF);
        check("wr5_b", oReadData2, 32'hDEADBEEF);
        check("wr5_count", {16'h0, oWriteCount}, 32'd1);

        iRegWrite = 1'b1; iWriteReg = 4'd0; iWriteData = 32'hFFFFFFFF;
        tick();
        iRegWrite = 1'b0;
        read_all(4'd0);
        check("wr0_a", oReadData1, 32'h0);
        check("wr0_b", oReadData2, 32'h0);
        check("wr0_d", oDispData, 32'h0);
        check("wr0_count", {16'h0, oWriteCount}, 32'd1);

        iRegWrite = 1'b1; iWriteReg = 4'd7; iWriteData = 32'h1234;
        iReadReg1 = 4'd7; iDispReg = 4'd7;
        #1;
`ifdef REGBANK_BYPASS_EN
        check("same_cyc_a", oReadData1, 32'h1234);
`else
        check("same_cyc_a", oReadData1, 32'h0);
`endif
        check("same_cyc_d", oDispData, 32'h0);
        tick();
        iRegWrite = 1'b0;
        #1;
        check("after_a", oReadData1, 32'h1234);
        check("after_d", oDispData, 32'h1234);
        check("after_count", {16'h0, oWriteCount}, 32'd2);

        iRST = 1'b1; iRegWrite = 1'b1; iWriteReg = 4'd3; iWriteData = 32'hAA;
        tick();
        iRST = 1'b0; iRegWrite = 1'b0;
        read_all(4'd3);
        check("rstwr_r3", oReadData1, 32'h0);
        check("rstwr_count", {16'h0, oWriteCount}, 32'h0);
        read_all(4'd5);
        check("rstwr_r5", oReadData2, 32'h0);
        read_all(4'd13);
        check("rstwr_sp", oDispData, 32'h1001_03FC);

        iRegWrite = 1'b1; iWriteReg = 4'd1;
        for (int i = 0; i < 65535; i++) begin
            iWriteData = 32'(i);
            tick();
        end
        check("cnt_ffff", {16'h0, oWriteCount}, 32'h0000FFFF);
        iWriteData = 32'hCAFE0001;
        tick();
        iRegWrite = 1'b0;
        read_all(4'd1);
        check("cnt_wrap", {16'h0, oWriteCount}, 32'h0);
        check("wrap_r1", oReadData1, 32'hCAFE0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
